// File: rtl/pipeline_seq_ctrl.sv
// pipeline_seq_ctrl: central sequencer for a 5-stage MIPS pipeline.
// Turns the hazard flag, EX-stage branch redirect and memory handshakes into
// per-stage load enables, flushes and bubbles. It also counts cycles in which
// the PC did not advance and traps a data memory that never answers.
module pipeline_seq_ctrl #(
    parameter int FLUSH_CYCLES  = 2,    // cycles IF/ID + ID/EX are squashed after a redirect
    parameter int DWAIT_TIMEOUT = 255,  // consecutive dmem wait cycles before the trap
    parameter int CNT_W         = 16    // width of the lost-cycle counter
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,         // 0 = hazard (hold ID), 1 = free
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        FLUSH = 2'd2,
        ERR   = 2'd3
    } state_t;

    // The flush counter holds at most FLUSH_CYCLES-1. The wait counter must
    // reach DWAIT_TIMEOUT.
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WW = $clog2(DWAIT_TIMEOUT + 1);

    localparam logic [FW-1:0] FLUSH_RELOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX     = WW'(DWAIT_TIMEOUT);

    state_t            state_q;
    logic [FW-1:0]     flush_cnt_q;
    logic [WW-1:0]     wait_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              err_q;
    logic              dmem_miss;

    assign dmem_miss = dmem_req & ~dmem_ready;
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign err       = err_q;

    // Stage controls: decoded from the current state and this cycle's inputs.
    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves one
        // unassigned. An unassigned path would infer a latch.
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;

        unique case (state_q)
            RUN: begin
                if (dmem_miss) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                end else if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (!stall) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (!imem_ready) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
            DWAIT: begin
                // Freeze until the memory answers. The answering cycle advances.
                if (!dmem_ready) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                end
            end
            FLUSH: begin
                if (dmem_miss) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                end else begin
                    pc_en       = imem_ready;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            ERR: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end
        endcase

        // While reset is held, the pipeline is forced to load NOPs and hold the PC.
        if (reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end
    end

    // Sequencer state, flush/wait counters, sticky trap and lost-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so that every flop
        // samples values from before the edge.
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (!pc_en && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                RUN: begin
                    if (dmem_miss) begin
                        state_q    <= DWAIT;
                        wait_cnt_q <= WW'(1);
                    end else if (branch_taken) begin
                        flush_cnt_q <= FLUSH_RELOAD;
                        if (FLUSH_CYCLES > 1) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                DWAIT: begin
                    if (dmem_ready) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_MAX) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WW'(1);
                    end
                end
                FLUSH: begin
                    // A data miss freezes the flush in place. A newer redirect
                    // restarts the flush.
                    if (!dmem_miss) begin
                        if (branch_taken) begin
                            flush_cnt_q <= FLUSH_RELOAD;
                            if (FLUSH_CYCLES == 1) begin
                                state_q <= RUN;
                            end
                        end else if (imem_ready) begin
                            flush_cnt_q <= flush_cnt_q - FW'(1);
                            if (flush_cnt_q == FW'(1)) begin
                                state_q <= RUN;
                            end
                        end
                    end
                end
                ERR: begin
                    err_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// Scoreboard bench for pipeline_seq_ctrl. The stimulus side pushes
// hand-computed expectations. A monitor pops each expectation on the falling
// edge and compares it against the outputs of the selected instance.
// Instance A uses the default parameters. Instance B uses a 3-cycle dmem
// timeout and a 3-bit counter, so both the trap and counter saturation are reachable.
module tb_pipeline_seq_ctrl;

    // Output vector order: {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble}
    localparam logic [5:0] ADV  = 6'b110010;  // advance
    localparam logic [5:0] FRZ  = 6'b000001;  // freeze
    localparam logic [5:0] RSTV = 6'b001101;  // reset / error outputs
    localparam logic [5:0] BRV  = 6'b111110;  // RUN branch, or FLUSH with imem_ready
    localparam logic [5:0] FLN  = 6'b011110;  // FLUSH without imem_ready
    localparam logic [5:0] STL  = 6'b000110;  // hazard stall
    localparam logic [5:0] NIM  = 6'b011010;  // fetch not ready

    logic clk = 1'b0;
    logic reset, reset_t;
    logic stall, branch_taken, imem_ready, dmem_req, dmem_ready;

    logic        pc_en_a, ifid_en_a, ifid_flush_a, idex_bubble_a, exmem_en_a, memwb_bubble_a, err_a;
    logic [1:0]  state_a;
    logic [15:0] stall_cnt_a;
    logic        pc_en_b, ifid_en_b, ifid_flush_b, idex_bubble_b, exmem_en_b, memwb_bubble_b, err_b;
    logic [1:0]  state_b;
    logic [2:0]  stall_cnt_b;

    pipeline_seq_ctrl dut_a (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a),
        .idex_bubble(idex_bubble_a), .exmem_en(exmem_en_a), .memwb_bubble(memwb_bubble_a),
        .err(err_a), .state(state_a), .stall_cnt(stall_cnt_a)
    );

    pipeline_seq_ctrl #(.FLUSH_CYCLES(2), .DWAIT_TIMEOUT(3), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset_t), .stall(stall), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b),
        .idex_bubble(idex_bubble_b), .exmem_en(exmem_en_b), .memwb_bubble(memwb_bubble_b),
        .err(err_b), .state(state_b), .stall_cnt(stall_cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         inst;
        logic [5:0] o;
        logic [1:0] st;
        logic       er;
        int         sc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_sc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Apply one cycle of inputs after the rising edge and queue its expectation.
    // Only the selected instance sees rs; the other instance is held in reset.
    task automatic step(input bit inst, input logic rs, input logic st, input logic br,
                        input logic im, input logic dq, input logic dr,
                        input logic [5:0] eo, input logic [1:0] es, input logic ee,
                        input string nm);
        exp_t e;
        int   sat;
        @(posedge clk);
        #1;
        reset        = inst ? 1'b1 : rs;
        reset_t      = inst ? rs : 1'b1;
        stall        = st;
        branch_taken = br;
        imem_ready   = im;
        dmem_req     = dq;
        dmem_ready   = dr;
        if (rs) exp_sc = 0;
        e.inst = inst;
        e.o    = eo;
        e.st   = es;
        e.er   = ee;
        e.sc   = exp_sc;
        e.name = nm;
        sb.push_back(e);
        sat = inst ? 7 : 65535;
        if (!rs && !eo[5] && exp_sc < sat) exp_sc++;
    endtask

    // Monitor: one expectation per falling edge, compared against the selected instance.
    exp_t        mon_e;
    logic [5:0]  mon_o;
    logic [1:0]  mon_st;
    logic        mon_er;
    logic [31:0] mon_sc;
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (mon_e.inst) begin
                    mon_o  = {pc_en_b, ifid_en_b, ifid_flush_b, idex_bubble_b, exmem_en_b, memwb_bubble_b};
                    mon_st = state_b;
                    mon_er = err_b;
                    mon_sc = 32'(stall_cnt_b);
                end else begin
                    mon_o  = {pc_en_a, ifid_en_a, ifid_flush_a, idex_bubble_a, exmem_en_a, memwb_bubble_a};
                    mon_st = state_a;
                    mon_er = err_a;
                    mon_sc = 32'(stall_cnt_a);
                end
                check($sformatf("%s.outs", mon_e.name), 32'(mon_o), 32'(mon_e.o));
                check($sformatf("%s.state", mon_e.name), 32'(mon_st), 32'(mon_e.st));
                check($sformatf("%s.err", mon_e.name), 32'(mon_er), 32'(mon_e.er));
                check($sformatf("%s.stall_cnt", mon_e.name), mon_sc, 32'(mon_e.sc));
            end
        end
    end

    initial begin
        reset = 1'b1; reset_t = 1'b1;
        stall = 1'b1; branch_taken = 1'b0; imem_ready = 1'b1;
        dmem_req = 1'b0; dmem_ready = 1'b0;

        // Reset values on instance A.
        step(0,1,1,0,1,0,0,RSTV,2'd0,0,"reset");
        step(0,1,1,0,1,0,0,RSTV,2'd0,0,"reset");
        // T1: free-running advance.
        for (int i = 0; i < 10; i++) step(0,0,1,0,1,0,0,ADV,2'd0,0,"t1_adv");
        // T2: three hazard cycles, then the count shows 3.
        for (int i = 0; i < 3; i++) step(0,0,0,0,1,0,0,STL,2'd0,0,"t2_stall");
        step(0,0,1,0,1,0,0,ADV,2'd0,0,"t2_after");
        // T3: branch redirect with a 2-cycle flush.
        step(0,0,1,1,1,0,0,BRV,2'd0,0,"t3_branch");
        step(0,0,1,0,1,0,0,BRV,2'd2,0,"t3_flush");
        step(0,0,1,0,1,0,0,ADV,2'd0,0,"t3_run");
        // RUN priorities: fetch miss, stall over fetch miss, branch over stall.
        step(0,0,1,0,0,0,0,NIM,2'd0,0,"run_noimem");
        step(0,0,0,0,0,0,0,STL,2'd0,0,"stall_over_noimem");
        step(0,0,0,1,1,0,0,BRV,2'd0,0,"br_over_stall");
        step(0,0,1,0,1,0,0,BRV,2'd2,0,"br_over_stall_flush");
        // T4: fresh reset, then 4 miss cycles and completion.
        step(0,1,1,0,1,0,0,RSTV,2'd0,0,"t4_reset");
        step(0,0,1,0,1,1,0,FRZ,2'd0,0,"t4_miss");
        for (int i = 0; i < 3; i++) step(0,0,1,0,1,1,0,FRZ,2'd1,0,"t4_wait");
        step(0,0,1,0,1,1,1,ADV,2'd1,0,"t4_done");
        step(0,0,1,0,1,0,0,ADV,2'd0,0,"t4_run");
        // T6: branch and miss together, then a miss inside FLUSH.
        step(0,0,1,1,1,1,0,FRZ,2'd0,0,"t6_br_miss");
        step(0,0,1,1,1,1,0,FRZ,2'd1,0,"t6_wait");
        step(0,0,1,1,1,1,1,ADV,2'd1,0,"t6_ready");
        step(0,0,1,1,1,0,0,BRV,2'd0,0,"t6_branch");
        step(0,0,1,0,1,1,0,FRZ,2'd2,0,"t6_flush_miss");
        step(0,0,1,0,1,1,0,FRZ,2'd2,0,"t6_flush_miss");
        step(0,0,1,0,0,0,0,FLN,2'd2,0,"t6_flush_noimem");
        step(0,0,1,0,1,0,0,BRV,2'd2,0,"t6_flush_go");
        step(0,0,1,0,1,0,0,ADV,2'd0,0,"t6_run");
        // A redirect during FLUSH restarts the flush.
        step(0,0,1,1,1,0,0,BRV,2'd0,0,"reload_br1");
        step(0,0,1,1,1,0,0,BRV,2'd2,0,"reload_br2");
        step(0,0,1,0,1,0,0,BRV,2'd2,0,"reload_tail");
        step(0,0,1,0,1,0,0,ADV,2'd0,0,"reload_run");
        // Reset in the middle of FLUSH and in the middle of DWAIT.
        step(0,0,1,1,1,0,0,BRV,2'd0,0,"flush_enter");
        step(0,1,1,0,1,0,0,RSTV,2'd0,0,"flush_reset");
        step(0,0,1,0,1,0,0,ADV,2'd0,0,"flush_post_reset");
        step(0,0,1,0,1,1,0,FRZ,2'd0,0,"dwait_enter");
        step(0,0,1,0,1,1,0,FRZ,2'd1,0,"dwait_hold");
        step(0,1,1,0,1,1,0,RSTV,2'd0,0,"dwait_reset");
        step(0,0,1,0,1,0,0,ADV,2'd0,0,"dwait_post_reset");

        // T5 on instance B: timeout trap, sticky error, counter saturation, reset exit.
        step(1,1,1,0,1,0,0,RSTV,2'd0,0,"t5_reset");
        step(1,0,1,0,1,0,0,ADV,2'd0,0,"t5_adv");
        step(1,0,1,0,1,1,0,FRZ,2'd0,0,"t5_miss");
        for (int i = 0; i < 3; i++) step(1,0,1,0,1,1,0,FRZ,2'd1,0,"t5_wait");
        for (int i = 0; i < 5; i++) step(1,0,1,0,1,1,0,RSTV,2'd3,1,"t5_err");
        step(1,0,1,0,1,1,1,RSTV,2'd3,1,"t5_err_ready");
        step(1,1,1,0,1,0,0,RSTV,2'd0,0,"t5_reset2");
        step(1,0,1,0,1,0,0,ADV,2'd0,0,"t5_after");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
